// File: rtl/mips_boot_pkg.sv
// mips_boot_pkg: shared state encoding and stream layout constants for the MIPS boot loader.
package mips_boot_pkg;
    typedef enum logic [2:0] {
        HDR  = 3'd0,
        LOAD = 3'd1,
        CHK  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;
    localparam int BYTES_PER_WORD = 4;
    // Header is one little-endian 32-bit word holding the image word count.
    localparam int HDR_CNT_LSB = 0;
    localparam int HDR_CNT_W   = 32;
endpackage

// File: rtl/mips_byte_assembler.sv
// mips_byte_assembler: packs accepted bytes little-endian into 32-bit words,
// pulsing word_valid_o for one cycle after the fourth byte of each word.
module mips_byte_assembler
    import mips_boot_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);
    logic [$clog2(BYTES_PER_WORD)-1:0] cnt_q;
    logic [31:0] word_q;
    logic        vld_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            word_q <= '0;
            vld_q  <= 1'b0;
        end else if (clr_i) begin
            cnt_q  <= '0;
            word_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= byte_en_i && (&cnt_q);
            if (byte_en_i) begin
                cnt_q  <= cnt_q + 1'b1;
                word_q <= {byte_i, word_q[31:8]};
            end
        end
    end

    assign word_valid_o = vld_q;
    assign word_o       = word_q;
endmodule

// File: rtl/mips_boot_loader.sv
// mips_boot_loader: loads a counted byte-stream image into instruction memory and holds
// the core in reset until done. Define MIPS_BOOT_CHECKSUM_EN for a trailing XOR checksum word.
module mips_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  core_rst,
    output logic                  load_done,
    output logic                  load_err
);
    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;
`ifdef MIPS_BOOT_CHECKSUM_EN
    localparam state_t AFTER_LOAD = CHK;
`else
    localparam state_t AFTER_LOAD = DONE;
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, last_q;
    logic                  core_rst_q, done_q, err_q;
    logic                  word_valid, clr;
    logic [31:0]           word, hdr_cnt;
`ifdef MIPS_BOOT_CHECKSUM_EN
    logic [31:0]           csum_q;
`endif

    assign clr     = reload && (state_q == DONE || state_q == ERR);
    assign hdr_cnt = word[HDR_CNT_LSB +: HDR_CNT_W];

    mips_byte_assembler u_asm (
        .clk_i       (clk),
        .rst_ni      (rst),
        .clr_i       (clr),
        .byte_en_i   (byte_valid && byte_ready),
        .byte_i      (byte_data),
        .word_valid_o(word_valid),
        .word_o      (word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= HDR;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            core_rst_q <= state_d != DONE;
            done_q     <= state_d == DONE;
            err_q      <= state_d == ERR;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HDR: if (word_valid)
                state_d = hdr_cnt == '0 ? AFTER_LOAD : ({1'b0, hdr_cnt} > MAX_WORDS ? ERR : LOAD);
            LOAD: if (word_valid && idx_q == last_q) state_d = AFTER_LOAD;
`ifdef MIPS_BOOT_CHECKSUM_EN
            CHK: if (word_valid) state_d = word == csum_q ? DONE : ERR;
`endif
            DONE, ERR: if (reload) state_d = HDR;
            default: state_d = HDR;
        endcase
    end

    always_comb begin
        byte_ready = rst && (state_q == HDR || state_q == LOAD || state_q == CHK);
        imem_we    = state_q == LOAD && word_valid;
    end

    // The word index wraps to 0 after a full MAX_WORDS image, so it is already clear for the next load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= '0;
            last_q <= '0;
`ifdef MIPS_BOOT_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            if (clr) idx_q <= '0;
            else if (imem_we) idx_q <= idx_q + 1'b1;
            if (state_q == HDR && word_valid) last_q <= hdr_cnt[ADDR_WIDTH-1:0] - 1'b1;
`ifdef MIPS_BOOT_CHECKSUM_EN
            if (state_q == HDR && word_valid) csum_q <= hdr_cnt;
            else if (imem_we) csum_q <= csum_q ^ word;
`endif
        end
    end

    assign imem_addr  = idx_q;
    assign imem_wdata = word;
    assign core_rst   = core_rst_q;
    assign load_done  = done_q;
    assign load_err   = err_q;
endmodule

// File: doc/mips_boot_loader.md
Name: mips_boot_loader

Overview:
Upstream boot stage for the multicycle MIPS core. Receives a byte stream (valid/ready) carrying a word-count header and a program image. Assembles the bytes into 32-bit words and writes them into instruction memory from address 0. Holds the core in reset until the image is fully loaded, then releases it so the core fetches from PC=0.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; MAX_WORDS = 2**ADDR_WIDTH
DATA_WIDTH, 32, instruction word width; fixed at 32, other values unsupported

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle
reload  input  1  single-cycle pulse; restarts loading, honoured only in DONE or ERR
imem_we  output  1  instruction-memory write strobe
imem_addr  output  ADDR_WIDTH  word address
imem_wdata  output  32  word to write
core_rst  output  1  active-high reset to the MIPS core
load_done  output  1  image loaded, core running
load_err  output  1  image rejected

Behaviour:
- Reset (rst=0, asynchronous):
  - state=HDR, byte counter=0, word index=0.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - core_rst=1, load_done=0, load_err=0.
  - byte_ready=0 while rst is low.
- Handshake: a byte transfers only when byte_valid && byte_ready are both high on a clk edge. byte_ready=1 in HDR and LOAD (and CHK), 0 in DONE and ERR. Arbitrary valid gaps are allowed and the byte counter holds during them.
- Byte order is little-endian: byte 0 → bits[7:0], byte 3 → bits[31:24].
- States:
  - HDR: collect 4 bytes into the count N.
    - N==0 → DONE.
    - N > MAX_WORDS → ERR.
    - Otherwise → LOAD.
  - LOAD: on acceptance of the 4th byte of each word, the next cycle has imem_we=1 for exactly one cycle, imem_addr=word index, imem_wdata=assembled word. The word index then increments. A byte may be accepted in the same cycle as the write strobe.
  - After the write of word N−1, the next state is DONE (or CHK with the optional feature).
  - DONE: core_rst=0 and load_done=1, both registered. They change in the cycle after the final imem_we.
  - ERR: load_err=1, core_rst stays 1, no further writes.
  - reload in DONE or ERR → HDR:
    - core_rst=1 and load_done=0 in the next cycle; load_err clears.
    - Counters return to 0.
  - reload in any other state is ignored.
- N==MAX_WORDS is legal. The word index wraps to 0 after the final write and is never reused in that load.
- If rst is asserted mid-load, the partial image stays in memory and loading restarts at HDR.
- imem_we is never high outside LOAD, apart from the single trailing strobe cycle.

Optional Feature:
Macro: MIPS_BOOT_CHECKSUM_EN.
- Defined:
  - After the N words, a CHK state accepts 4 more bytes.
  - These bytes form a checksum word, compared with the XOR of the header count and all N data words.
  - Match → DONE. Mismatch → ERR.
  - N==0 still requires the checksum word, which is then equal to 0.
- Undefined: no CHK state, no trailing word, and the XOR accumulator is absent.

Decomposition:
- Shared package mips_boot_pkg holds:
  - state encoding localparams: HDR=0, LOAD=1, CHK=2, DONE=3, ERR=4;
  - BYTES_PER_WORD=4;
  - the header layout constant.
- One sub-module, mips_byte_assembler:
  - holds the 2-bit byte counter and 32-bit shift register;
  - outputs word_valid as a one-cycle pulse plus the assembled word;
  - is cleared by the parent on reload.

Test Plan:
1. Stream header 3, then words 0x20080005, 0x20090007, 0x01095020 (bytes LSB first, no gaps) → three imem_we pulses at addr 0, 1, 2 with those words; core_rst falls and load_done rises the cycle after the third write.
2. Header 0 → no imem_we; load_done=1 and core_rst=0 within 2 cycles of the 4th header byte.
3. Header MAX_WORDS+1 (257 at ADDR_WIDTH=8) → load_err=1, core_rst stays 1, byte_ready=0, no writes; then pulse reload → state HDR and load_err=0.
4. Random byte_valid gaps, with the load from scenario 1 repeated → identical write sequence, each strobe one cycle after the 4th accepted byte of its word.
5. Drive rst low after 6 bytes of a 3-word load, then release and send a fresh 2-word image → writes restart at addr 0, core_rst=1 throughout the load.
6. (MIPS_BOOT_CHECKSUM_EN) Scenario 1 followed by the correct XOR word → DONE; the same with a single bit flipped → ERR and core_rst=1.
